// File: rtl/chrono_pkg.sv
// Shared types and BCD digit helpers for the lap chronometer.
package chrono_pkg;

    localparam int unsigned BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        RECALL = 2'd3
    } state_t;

    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
        return (d >= BCD_W'(9)) ? '0 : d + BCD_W'(1);
    endfunction

    function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] d);
        return (d == '0) ? BCD_W'(9) : d - BCD_W'(1);
    endfunction

endpackage

// File: rtl/lap_chronometer_tick_gen.sv
// Count-rate enable divider: one-cycle tick every CLK_FPGA/TICK_HZ enabled cycles.
module tick_gen #(
    parameter int unsigned CLK_FPGA = 100000000,
    parameter int unsigned TICK_HZ  = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned DIV_RAW = CLK_FPGA / TICK_HZ;
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic             at_end;

    // Tick is combinational so a tick landing with a stop pulse is still applied.
    assign at_end = (cnt == CNT_W'(DIV - 1));
    assign tick   = en && at_end;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_end ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/lap_chronometer.sv
// BCD stopwatch with lap capture into external RAM and lap recall.
// Optional countdown mode (down/expired ports) when LAP_CHRONO_COUNTDOWN_EN is defined.
module lap_chronometer
    import chrono_pkg::*;
#(
    parameter int unsigned CLK_FPGA  = 100000000,
    parameter int unsigned TICK_HZ   = 100,
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned ADDR_SIZE = 4,
    parameter int unsigned DATA_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 restart,
    input  logic                 lap,
    input  logic                 recall,
`ifdef LAP_CHRONO_COUNTDOWN_EN
    input  logic                 down,
    output logic                 expired,
`endif
    output logic [DATA_SIZE-1:0] value,
    output logic                 running,
    output logic [ADDR_SIZE:0]   lap_count,
    output logic                 lap_full,
    output logic                 overflow,
    output logic [ADDR_SIZE-1:0] rd_addr,
    input  logic [DATA_SIZE-1:0] rd_data,
    output logic [ADDR_SIZE-1:0] wr_addr,
    output logic [DATA_SIZE-1:0] wr_data,
    output logic                 wr_en
);

    localparam int unsigned CW    = ADDR_SIZE + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_SIZE;

    state_t                 state_q, state_d;
    logic                   tick;
    logic [DATA_SIZE-1:0]   time_q, time_d, time_inc, value_d;
    logic                   inc_wrap, wrap_c, start_ok;
    logic                   do_stop, do_start, do_recall, do_lap;
    logic                   lap_acc, recall_acc;
    logic [ADDR_SIZE-1:0]   rd_ptr, rd_ptr_nxt;
    logic [1:0]             rd_pend;
`ifdef LAP_CHRONO_COUNTDOWN_EN
    logic [DATA_SIZE-1:0]   time_dec;
    logic                   expire_c;
`endif

    tick_gen #(
        .CLK_FPGA (CLK_FPGA),
        .TICK_HZ  (TICK_HZ)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == RUN),
        .clr  (state_q == IDLE),
        .tick (tick)
    );

    // Pulse priority below restart: stop > start > recall > lap.
    assign do_stop   = stop;
    assign do_start  = start && !stop;
    assign do_recall = recall && !stop && !start;
    assign do_lap    = lap && !stop && !start && !recall;

    assign rd_ptr_nxt = ((CW'(rd_ptr) + CW'(1)) == lap_count) ? '0 : rd_ptr + ADDR_SIZE'(1);

    // Ripple BCD increment: a digit moves only when all lower digits are 9.
    always_comb begin
        logic carry;
        time_inc = time_q;
        carry    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) time_inc[i*BCD_W +: BCD_W] = bcd_inc(time_q[i*BCD_W +: BCD_W]);
            carry = carry && (time_q[i*BCD_W +: BCD_W] == BCD_W'(9));
        end
        inc_wrap = carry;
    end

`ifdef LAP_CHRONO_COUNTDOWN_EN
    always_comb begin
        logic borrow;
        time_dec = time_q;
        borrow   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) time_dec[i*BCD_W +: BCD_W] = bcd_dec(time_q[i*BCD_W +: BCD_W]);
            borrow = borrow && (time_q[i*BCD_W +: BCD_W] == '0);
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        wrap_c     = 1'b0;
        start_ok   = 1'b1;
        lap_acc    = 1'b0;
        recall_acc = 1'b0;
        value_d    = value;
`ifdef LAP_CHRONO_COUNTDOWN_EN
        expire_c   = 1'b0;
        start_ok   = !(down && (time_q == '0));
`endif
        if (tick) begin
`ifdef LAP_CHRONO_COUNTDOWN_EN
            if (down) begin
                time_d   = (time_q == '0) ? '0 : time_dec;
                expire_c = (time_q == '0) || (time_dec == '0);
            end else begin
                time_d = time_inc;
                wrap_c = inc_wrap;
            end
`else
            time_d = time_inc;
            wrap_c = inc_wrap;
`endif
        end
        if (restart) begin
            state_d = IDLE;
            time_d  = '0;
            wrap_c  = 1'b0;
`ifdef LAP_CHRONO_COUNTDOWN_EN
            expire_c = 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (do_start && start_ok) state_d = RUN;
                end
                RUN: begin
                    if (do_stop) state_d = PAUSED;
`ifdef LAP_CHRONO_COUNTDOWN_EN
                    else if (expire_c) state_d = PAUSED;
`endif
                    lap_acc = do_lap && !lap_full;
                end
                PAUSED: begin
                    if (do_start && start_ok) begin
                        state_d = RUN;
                    end else if (do_recall && (lap_count != '0)) begin
                        state_d    = RECALL;
                        recall_acc = 1'b1;
                    end
                end
                RECALL: begin
                    if (do_start && start_ok) state_d = RUN;
                    else recall_acc = do_recall && (lap_count != '0);
                end
                default: state_d = IDLE;
            endcase
        end
        // Outside RECALL the display tracks live time; in RECALL it loads landed RAM reads.
        if (state_d != RECALL) value_d = time_d;
        else if (rd_pend[1]) value_d = rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            time_q    <= '0;
            value     <= '0;
            running   <= 1'b0;
            lap_count <= '0;
            lap_full  <= 1'b0;
            overflow  <= 1'b0;
            rd_ptr    <= '0;
            rd_addr   <= '0;
            rd_pend   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
`ifdef LAP_CHRONO_COUNTDOWN_EN
            expired   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            value   <= value_d;
            running <= (state_d == RUN);
            wr_en   <= lap_acc;
            rd_pend <= (state_d == RECALL) ? {rd_pend[0], recall_acc} : 2'b00;
`ifdef LAP_CHRONO_COUNTDOWN_EN
            expired <= expire_c;
`endif
            if (wrap_c) overflow <= 1'b1;
            if (lap_acc) begin
                wr_addr   <= lap_count[ADDR_SIZE-1:0];
                wr_data   <= time_q;
                lap_count <= lap_count + CW'(1);
                lap_full  <= (lap_count == CW'(DEPTH - 1));
            end
            if (recall_acc) begin
                rd_addr <= rd_ptr;
                rd_ptr  <= rd_ptr_nxt;
            end else if ((state_q == RECALL) && (state_d != RECALL)) begin
                rd_ptr <= '0;
            end
            if (restart) begin
                lap_count <= '0;
                lap_full  <= 1'b0;
                overflow  <= 1'b0;
                rd_ptr    <= '0;
                rd_addr   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lap_chronometer.sv
// Directed bench for lap_chronometer with an integer-time reference model and lap RAM.
module tb_lap_chronometer;

    localparam int TB_CLK = 4;
    localparam int TB_HZ  = 1;
    localparam int DIG    = 4;
    localparam int AW     = 2;
    localparam int DW     = 16;
    localparam int DEPTH  = 1 << AW;
    localparam int DIV    = (TB_CLK / TB_HZ < 1) ? 1 : TB_CLK / TB_HZ;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_RECALL = 3;

    logic          clk = 1'b0;
    logic          rst, start, stop, restart, lap, recall, down;
    logic [DW-1:0] value, rd_data, wr_data;
    logic          running, lap_full, overflow, wr_en;
    logic [AW:0]   lap_count;
    logic [AW-1:0] rd_addr, wr_addr;
`ifdef LAP_CHRONO_COUNTDOWN_EN
    logic          expired;
`endif

    int n_chk = 0;
    int n_err = 0;

    lap_chronometer #(
        .CLK_FPGA (TB_CLK),
        .TICK_HZ  (TB_HZ),
        .DIGITS   (DIG),
        .ADDR_SIZE(AW),
        .DATA_SIZE(DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .restart  (restart),
        .lap      (lap),
        .recall   (recall),
`ifdef LAP_CHRONO_COUNTDOWN_EN
        .down     (down),
        .expired  (expired),
`endif
        .value    (value),
        .running  (running),
        .lap_count(lap_count),
        .lap_full (lap_full),
        .overflow (overflow),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en)
    );

    always #5 clk = ~clk;

    // External lap RAM with one-cycle read latency.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (wr_en) ram[wr_addr] <= wr_data;
        rd_data <= ram[rd_addr];
    end

    function automatic logic [DW-1:0] to_bcd(input int v);
        logic [DW-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIG; i++) begin
            r[i*4 +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time as a plain integer, laps as an integer array.
    int m_state, m_time, m_phase, m_cnt, m_ptr, m_rdaddr, m_value, m_wr_addr, m_wr_data, cyc;
    bit m_ovf, m_wr, m_exp;
    int m_laps [DEPTH];
    int due_q[$];
    int dat_q[$];

    always @(posedge clk) begin
        bit tick, start_ok;
        int cmd, ns, t0;
        cyc++;
        if (rst) begin
            m_state = S_IDLE; m_time = 0; m_phase = 0; m_cnt = 0; m_ptr = 0;
            m_rdaddr = 0; m_value = 0; m_ovf = 0; m_wr = 0; m_exp = 0;
            due_q.delete(); dat_q.delete();
        end else begin
            tick = (m_state == S_RUN) && (m_phase == DIV - 1);
            if (m_state == S_RUN) m_phase = (m_phase + 1) % DIV;
            else if (m_state == S_IDLE) m_phase = 0;
            cmd = restart ? 1 : stop ? 2 : start ? 3 : recall ? 4 : lap ? 5 : 0;
            t0 = m_time;
            start_ok = !(down && t0 == 0);
            m_wr = 0;
            m_exp = 0;
            ns = m_state;
            if (tick) begin
                if (down) begin
                    if (m_time > 0) m_time--;
                    if (m_time == 0) m_exp = 1;
                end else begin
                    m_time++;
                    if (m_time == 10 ** DIG) begin m_time = 0; m_ovf = 1; end
                end
            end
            case (cmd)
                1: begin
                    ns = S_IDLE; m_time = 0; m_cnt = 0; m_ptr = 0; m_rdaddr = 0;
                    m_ovf = 0; m_exp = 0;
                end
                2: if (m_state == S_RUN) ns = S_PAUSED;
                3: if (m_state != S_RUN && start_ok) ns = S_RUN;
                4: if ((m_state == S_PAUSED || m_state == S_RECALL) && m_cnt > 0) begin
                    ns = S_RECALL;
                    m_rdaddr = m_ptr;
                    due_q.push_back(cyc + 2);
                    dat_q.push_back(m_laps[m_ptr]);
                    m_ptr = (m_ptr + 1) % m_cnt;
                end
                5: if (m_state == S_RUN && m_cnt < DEPTH) begin
                    m_wr = 1; m_wr_addr = m_cnt; m_wr_data = t0;
                    m_laps[m_cnt] = t0; m_cnt++;
                end
                default: ;
            endcase
            if (m_exp) ns = S_PAUSED;
            if (m_state == S_RECALL && ns != S_RECALL) m_ptr = 0;
            if (ns != S_RECALL) begin
                due_q.delete(); dat_q.delete();
                m_value = m_time;
            end else if (due_q.size() > 0 && due_q[0] == cyc) begin
                m_value = dat_q[0];
                void'(due_q.pop_front());
                void'(dat_q.pop_front());
            end
            m_state = ns;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("value", value, to_bcd(m_value));
            chk("running", running, m_state == S_RUN);
            chk("lap_count", lap_count, m_cnt);
            chk("lap_full", lap_full, m_cnt == DEPTH);
            chk("overflow", overflow, m_ovf);
            chk("wr_en", wr_en, m_wr);
            chk("rd_addr", rd_addr, m_rdaddr);
            if (m_wr) begin
                chk("wr_addr", wr_addr, m_wr_addr);
                chk("wr_data", wr_data, to_bcd(m_wr_data));
            end
`ifdef LAP_CHRONO_COUNTDOWN_EN
            chk("expired", expired, m_exp);
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit s, input bit p, input bit r, input bit l, input bit rc);
        start = s; stop = p; restart = r; lap = l; recall = rc;
        @(negedge clk);
        start = 0; stop = 0; restart = 0; lap = 0; recall = 0;
    endtask

    initial begin
        rst = 1; start = 0; stop = 0; restart = 0; lap = 0; recall = 0; down = 0;
        step(3);
        chk("rst_value", value, 16'h0000);
        chk("rst_running", running, 0);
        chk("rst_lap_count", lap_count, 0);
        rst = 0;

        // Laps at 0005 and 0012, then run on to 0123.
        pulse(1, 0, 0, 0, 0);
        step(20);
        chk("t5_value", value, 16'h0005);
        pulse(0, 0, 0, 1, 0);
        chk("lap0_wr_en", wr_en, 1);
        chk("lap0_wr_data", wr_data, 16'h0005);
        step(27);
        pulse(0, 0, 0, 1, 0);
        chk("lap1_wr_addr", wr_addr, 1);
        chk("lap1_wr_data", wr_data, 16'h0012);
        chk("lap1_count", lap_count, 2);
        step(443);
        chk("t123_value", value, 16'h0123);
        chk("t123_running", running, 1);
        pulse(0, 1, 0, 0, 0);
        step(100);
        chk("paused_value", value, 16'h0123);
        chk("paused_running", running, 0);

        // Recall x3 with two laps stored.
        pulse(0, 0, 0, 0, 1);
        step(1);
        chk("recall0_early", value, 16'h0123);
        step(1);
        chk("recall0_value", value, 16'h0005);
        pulse(0, 0, 0, 0, 1);
        step(2);
        chk("recall1_value", value, 16'h0012);
        pulse(0, 0, 0, 0, 1);
        step(1);
        chk("recall2_early", value, 16'h0012);
        step(1);
        chk("recall2_value", value, 16'h0005);
        pulse(1, 0, 0, 0, 0);
        chk("resume_value", value, 16'h0123);
        chk("resume_running", running, 1);

        // Fill the 4-entry lap RAM, then one more lap is dropped.
        pulse(0, 0, 0, 1, 0);
        chk("lap2_wr_addr", wr_addr, 2);
        pulse(0, 0, 0, 1, 0);
        chk("lap3_count", lap_count, 4);
        chk("lap3_full", lap_full, 1);
        pulse(0, 0, 0, 1, 0);
        chk("lap_full_no_write", wr_en, 0);

        // Overflow from 9999.
        pulse(0, 0, 1, 0, 0);
        chk("restart_value", value, 16'h0000);
        chk("restart_lap_count", lap_count, 0);
        pulse(1, 0, 0, 0, 0);
        step(4 * 9999);
        chk("t9999_value", value, 16'h9999);
        chk("t9999_overflow", overflow, 0);
        step(4);
        chk("wrap_value", value, 16'h0000);
        chk("wrap_overflow", overflow, 1);
        pulse(0, 0, 1, 0, 0);
        chk("restart_overflow", overflow, 0);
        chk("restart_running", running, 0);

        // Stop coinciding with a tick; lap and empty recall while paused.
        pulse(1, 0, 0, 0, 0);
        step(11);
        pulse(0, 1, 0, 0, 0);
        chk("stop_on_tick", value, 16'h0003);
        pulse(0, 0, 0, 1, 0);
        chk("paused_lap_ignored", wr_en, 0);
        pulse(0, 0, 0, 0, 1);
        step(2);
        chk("empty_recall_value", value, 16'h0003);
        chk("empty_recall_running", running, 0);

`ifdef LAP_CHRONO_COUNTDOWN_EN
        down = 1;
        pulse(1, 0, 0, 0, 0);
        step(11);
        chk("cd_t1_value", value, 16'h0001);
        step(1);
        chk("cd_expired", expired, 1);
        chk("cd_value", value, 16'h0000);
        chk("cd_running", running, 0);
        step(1);
        chk("cd_expired_once", expired, 0);
        pulse(1, 0, 0, 0, 0);
        chk("cd_start_at_zero", running, 0);
        down = 0;
`endif

        // Same-cycle start and restart from PAUSED.
        pulse(1, 0, 1, 0, 0);
        chk("start_restart_value", value, 16'h0000);
        chk("start_restart_running", running, 0);
        step(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
